// File: rtl/load_store_sequencer_if.sv
// Request/response and byte-memory bus shared by the load/store sequencer,
// the requesting pipeline and the attached byte-wide data memory.
interface load_store_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] MemAdd;
    logic        MemRead;
    logic        MemWrite;
    logic [7:0]  WriteByte;
    logic [7:0]  ReadByte;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, ReadByte,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output MemAdd, MemRead, MemWrite, WriteByte
    );

    modport mem (
        input  MemAdd, MemRead, MemWrite, WriteByte,
        output ReadByte
    );
endinterface

// File: rtl/load_store_sequencer.sv
// Serialises RISC-V style byte/half/word/double loads and stores onto a
// single byte-wide memory port, one byte per cycle, little-endian.
module load_store_sequencer #(
    parameter int MEM_BYTES = 64
) (
    input logic                 clk,
    input logic                 reset,
    load_store_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        wr_p0;
    logic [2:0]  f3_p0;
    logic [63:0] addr_p0;
    logic [63:0] wdata_p0;
    logic [63:0] rdata_p0;
    logic        err_p0;
    logic [2:0]  idx_p0;

    logic        accept;
    logic        acc_err;
    logic        last_byte;
    logic [64:0] end_addr;

    function automatic logic [3:0] byte_count(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

    // Bytes above the access size are already zero (cleared at acceptance),
    // so zero-extension is simply the raw assembled value.
    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [2:0] f3);
        logic signed [63:0] sx;
        unique case (f3[1:0])
            2'b00:   sx = 64'(signed'(raw[7:0]));
            2'b01:   sx = 64'(signed'(raw[15:0]));
            2'b10:   sx = 64'(signed'(raw[31:0]));
            default: sx = signed'(raw);
        endcase
        return f3[2] ? raw : 64'(sx);
    endfunction

    // 65-bit sum so an address near 2^64 cannot wrap into range.
    assign end_addr  = {1'b0, bus.req_addr} + 65'(byte_count(bus.req_funct3[1:0]));
    assign acc_err   = (end_addr > 65'(MEM_BYTES)) || (bus.req_write && bus.req_funct3[2]);
    assign accept    = (state == IDLE) && bus.req_valid;
    assign last_byte = ({1'b0, idx_p0} == (byte_count(f3_p0[1:0]) - 4'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx_p0 <= 3'd0;
            err_p0 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                err_p0 <= acc_err;
                idx_p0 <= 3'd0;
            end else if (state == XFER) begin
                idx_p0 <= idx_p0 + 3'd1;
            end
        end
    end

    // ---- stage p0: latched request and assembled load data ----
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_p0    <= bus.req_write;
            f3_p0    <= bus.req_funct3;
            addr_p0  <= bus.req_addr;
            wdata_p0 <= bus.req_wdata;
            rdata_p0 <= '0;
        end else if ((state == XFER) && !wr_p0) begin
            rdata_p0[{idx_p0, 3'b000} +: 8] <= bus.ReadByte;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.req_valid) state_nxt = acc_err ? RESP : XFER;
            XFER:    if (last_byte) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p1: response and memory-port outputs ----
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        bus.resp_err   = (state == RESP) && err_p0;
        bus.resp_rdata = '0;
        bus.MemAdd     = '0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.WriteByte  = '0;
        if ((state == RESP) && !err_p0 && !wr_p0) begin
            bus.resp_rdata = extend(rdata_p0, f3_p0);
        end
        if (state == XFER) begin
            bus.MemAdd   = addr_p0 + 64'(idx_p0);
            bus.MemRead  = !wr_p0;
            bus.MemWrite = wr_p0;
            if (wr_p0) begin
                bus.WriteByte = wdata_p0[{idx_p0, 3'b000} +: 8];
            end
        end
    end

endmodule
